// File: rtl/bcd_digit_entry.sv
// -----------------------------------------------------------------------------
// bcd_digit_entry
//
// Push-button BCD digit entry. The operator sets a digit on the switches,
// then presses "enter" to commit it into the next slot. Slot 0 (the ones
// digit) is filled first. After NUM_DIGITS commits the pass completes: done
// pulses for one cycle, and the block waits in DONE. The next enter starts a
// new pass at slot 0. Slots not yet overwritten keep their old values.
// "cancel" aborts the pass in progress. It restores every slot committed
// during the pass from digits_old.
//
// Optional feature (macro BCD_ENTRY_BINARY_EN):
//   defined   : value_bin is a register. It loads the binary equivalent of
//               the digits on the edge that completes a pass.
//   undefined : value_bin is tied to 0 and no converter is built.
//               The port list is the same in both builds.
//
// Parameters
//   NUM_DIGITS  digits per pass (1..8)
//   DIGIT_MAX   clamp ceiling for an entered digit (0..9)
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   enter          raw push-button level: commit the current digit
//   cancel         raw push-button level: abort the current pass
//   value[3:0]     raw switch digit
//   current_value  value clamped to DIGIT_MAX (combinational)
//   digit_index    next slot to fill; NUM_DIGITS while in DONE
//   digits         committed digits, slot k at [4k+3:4k]
//   digits_old     each slot's value before its last commit
//   done           one-cycle pulse after the final commit of a pass
//   value_bin      binary equivalent of digits (0 when feature disabled)
// -----------------------------------------------------------------------------
module bcd_digit_entry #(
    parameter int NUM_DIGITS = 3,
    parameter int DIGIT_MAX  = 9
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enter,
    input  logic                                 cancel,
    input  logic [3:0]                           value,
    output logic [3:0]                           current_value,
    output logic [$clog2(NUM_DIGITS+1)-1:0]      digit_index,
    output logic [4*NUM_DIGITS-1:0]              digits,
    output logic [4*NUM_DIGITS-1:0]              digits_old,
    output logic                                 done,
    output logic [$clog2(10**NUM_DIGITS)-1:0]    value_bin
);

    localparam int IDX_W = $clog2(NUM_DIGITS + 1);
    localparam int VB_W  = $clog2(10**NUM_DIGITS);

    localparam logic [3:0]       MAX_DIGIT = 4'(DIGIT_MAX);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] DONE_IDX  = IDX_W'(NUM_DIGITS);

    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    // Saturate a raw switch digit to DIGIT_MAX.
    function automatic logic [3:0] clamp_digit(input logic [3:0] raw);
        if (raw > MAX_DIGIT) begin
            return MAX_DIGIT;
        end
        return raw;
    endfunction

    assign current_value = clamp_digit(value);

    // -------------------------------------------------------------------------
    // Button conditioning: two synchroniser flops, then an edge flop.
    //
    // The reset-cleared flops would otherwise make a button held high
    // through reset look like a fresh rising edge. To prevent that, each
    // detector is armed only after its synchronised level has been seen low.
    // The check uses real samples: fill_p1 marks that the synchroniser has
    // been clocked twice since reset.
    // -------------------------------------------------------------------------
    logic enter_sync_p0, enter_sync_p1, enter_edge_p2;
    logic cancel_sync_p0, cancel_sync_p1, cancel_edge_p2;
    logic fill_p0, fill_p1;
    logic enter_armed, cancel_armed;
    logic enter_evt, cancel_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_sync_p0  <= 1'b0;
            enter_sync_p1  <= 1'b0;
            enter_edge_p2  <= 1'b0;
            cancel_sync_p0 <= 1'b0;
            cancel_sync_p1 <= 1'b0;
            cancel_edge_p2 <= 1'b0;
            fill_p0        <= 1'b0;
            fill_p1        <= 1'b0;
            enter_armed    <= 1'b0;
            cancel_armed   <= 1'b0;
        end else begin
            enter_sync_p0  <= enter;
            enter_sync_p1  <= enter_sync_p0;
            enter_edge_p2  <= enter_sync_p1;
            cancel_sync_p0 <= cancel;
            cancel_sync_p1 <= cancel_sync_p0;
            cancel_edge_p2 <= cancel_sync_p1;
            fill_p0        <= 1'b1;
            fill_p1        <= fill_p0;
            enter_armed    <= enter_armed  | (fill_p1 & ~enter_sync_p1);
            cancel_armed   <= cancel_armed | (fill_p1 & ~cancel_sync_p1);
        end
    end

    // Each event is high for the single cycle before the third rising edge
    // that sampled the raw button high.
    assign enter_evt  = enter_sync_p1  & ~enter_edge_p2  & enter_armed;
    assign cancel_evt = cancel_sync_p1 & ~cancel_edge_p2 & cancel_armed;

    // -------------------------------------------------------------------------
    // Entry FSM and digit storage
    // -------------------------------------------------------------------------
    state_t                       state_q, state_n;
    logic [IDX_W-1:0]             idx_q, idx_n;
    logic [NUM_DIGITS-1:0][3:0]   digits_q, digits_n;
    logic [NUM_DIGITS-1:0][3:0]   old_q, old_n;
    logic                         done_q, done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_ENTRY;
            idx_q    <= '0;
            digits_q <= '0;
            old_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            digits_q <= digits_n;
            old_q    <= old_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        digits_n = digits_q;
        old_n    = old_q;
        done_n   = 1'b0;

        unique case (state_q)
            ST_ENTRY: begin
                if (cancel_evt) begin
                    // Cancel has priority over a coincident enter. It restores
                    // only the slots committed during this pass (below idx).
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (IDX_W'(k) < idx_q) begin
                            digits_n[k] = old_q[k];
                        end
                    end
                    idx_n = '0;
                end else if (enter_evt) begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (IDX_W'(k) == idx_q) begin
                            digits_n[k] = current_value;
                            old_n[k]    = digits_q[k];
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_n = ST_DONE;
                        idx_n   = DONE_IDX;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // Cancel is ignored here. It still swallows a coincident
                // enter, so a simultaneous press does nothing.
                if (enter_evt && !cancel_evt) begin
                    state_n = ST_ENTRY;
                    idx_n   = '0;
                end
            end
            default: begin
                state_n = ST_ENTRY;
                idx_n   = '0;
            end
        endcase
    end

    assign digit_index = idx_q;
    assign digits      = digits_q;
    assign digits_old  = old_q;
    assign done        = done_q;

    // -------------------------------------------------------------------------
    // Optional BCD-to-binary result register
    // -------------------------------------------------------------------------
`ifdef BCD_ENTRY_BINARY_EN
    // Horner evaluation, most significant digit first.
    // Every partial sum is below 10**NUM_DIGITS, so VB_W bits never overflow.
    function automatic logic [VB_W-1:0] bcd_to_bin(input logic [NUM_DIGITS-1:0][3:0] d);
        logic [VB_W-1:0] acc;
        acc = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            acc = acc * VB_W'(10) + VB_W'(d[k]);
        end
        return acc;
    endfunction

    logic [VB_W-1:0] bin_q;

    // Load from the post-commit digits on the same edge that raises done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
        end else if (done_n) begin
            bin_q <= bcd_to_bin(digits_n);
        end
    end

    assign value_bin = bin_q;
`else
    assign value_bin = '0;
`endif

endmodule

// File: tb/tb_bcd_digit_entry.sv
// -----------------------------------------------------------------------------
// tb_bcd_digit_entry
//
// Directed bench for bcd_digit_entry.
//   dut  : NUM_DIGITS=3, DIGIT_MAX=9
//   dut2 : NUM_DIGITS=1, DIGIT_MAX=6
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected value_bin depends on whether BCD_ENTRY_BINARY_EN is defined.
// -----------------------------------------------------------------------------
module tb_bcd_digit_entry;

`ifdef BCD_ENTRY_BINARY_EN
    localparam bit BIN_EN = 1'b1;
`else
    localparam bit BIN_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        enter;
    logic        cancel;
    logic        enter2;
    logic        cancel2;
    logic [3:0]  value;

    logic [3:0]  current_value;
    logic [1:0]  digit_index;
    logic [11:0] digits;
    logic [11:0] digits_old;
    logic        done;
    logic [9:0]  value_bin;

    logic [3:0]  current_value2;
    logic [0:0]  digit_index2;
    logic [3:0]  digits2;
    logic [3:0]  digits_old2;
    logic        done2;
    logic [3:0]  value_bin2;

    int passed;
    int total;
    int done_cnt;
    int done2_cnt;

    bcd_digit_entry #(.NUM_DIGITS(3), .DIGIT_MAX(9)) dut (
        .clk           (clk),
        .rst           (rst),
        .enter         (enter),
        .cancel        (cancel),
        .value         (value),
        .current_value (current_value),
        .digit_index   (digit_index),
        .digits        (digits),
        .digits_old    (digits_old),
        .done          (done),
        .value_bin     (value_bin)
    );

    bcd_digit_entry #(.NUM_DIGITS(1), .DIGIT_MAX(6)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .enter         (enter2),
        .cancel        (cancel2),
        .value         (value),
        .current_value (current_value2),
        .digit_index   (digit_index2),
        .digits        (digits2),
        .digits_old    (digits_old2),
        .done          (done2),
        .value_bin     (value_bin2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done-high cycles. A single one-cycle pulse adds exactly one.
    always @(negedge clk) begin
        if (done === 1'b1)  done_cnt++;
        if (done2 === 1'b1) done2_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Hold the selected buttons for 'hold' cycles (>=3 so the event lands),
    // then release them and let the synchroniser drain.
    task automatic press(input bit e, input bit c, input bit e2, input int hold);
        enter  = e;
        cancel = c;
        enter2 = e2;
        repeat (hold) @(negedge clk);
        enter  = 1'b0;
        cancel = 1'b0;
        enter2 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        done_cnt  = 0;
        done2_cnt = 0;
        rst     = 1'b1;
        enter   = 1'b0;
        cancel  = 1'b0;
        enter2  = 1'b0;
        cancel2 = 1'b0;
        value   = 4'd4;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_digits",     32'(digits),        32'h000);
        check("rst_old",        32'(digits_old),    32'h000);
        check("rst_index",      32'(digit_index),   32'd0);
        check("rst_done",       32'(done),          32'd0);
        check("rst_bin",        32'(value_bin),     32'd0);
        check("rst_cur",        32'(current_value), 32'd4);

        rst = 1'b0;
        repeat (5) @(negedge clk);

        // First pass: 5, 2, 1
        value = 4'd5;
        press(1'b1, 1'b0, 1'b0, 4);
        check("p1_idx1",    32'(digit_index), 32'd1);
        check("p1_dig1",    32'(digits),      32'h005);
        value = 4'd2;
        press(1'b1, 1'b0, 1'b0, 4);
        check("p1_idx2",    32'(digit_index), 32'd2);
        check("p1_done_early", 32'(done_cnt), 32'd0);
        value = 4'd1;
        press(1'b1, 1'b0, 1'b0, 4);
        check("p1_digits",  32'(digits),      32'h125);
        check("p1_old",     32'(digits_old),  32'h000);
        check("p1_idx3",    32'(digit_index), 32'd3);
        check("p1_donecnt", 32'(done_cnt),    32'd1);
        check("p1_done_lo", 32'(done),        32'd0);
        check("p1_bin",     32'(value_bin),   BIN_EN ? 32'd125 : 32'd0);

        // Clamp boundaries on both instances
        value = 4'd12;
        #1;
        check("clamp12",    32'(current_value),  32'd9);
        check("clamp12_d2", 32'(current_value2), 32'd6);
        value = 4'd9;
        #1;
        check("clamp9",     32'(current_value),  32'd9);
        value = 4'd6;
        #1;
        check("clamp6_d2",  32'(current_value2), 32'd6);
        value = 4'd7;
        #1;
        check("clamp7",     32'(current_value),  32'd7);
        check("clamp7_d2",  32'(current_value2), 32'd6);
        @(negedge clk);

        // Single-digit instance: every enter in ENTRY completes a pass
        press(1'b0, 1'b0, 1'b1, 4);
        check("d2_digits",  32'(digits2),      32'h6);
        check("d2_idx",     32'(digit_index2), 32'd1);
        check("d2_donecnt", 32'(done2_cnt),    32'd1);
        check("d2_bin",     32'(value_bin2),   BIN_EN ? 32'd6 : 32'd0);
        value = 4'd3;
        press(1'b0, 1'b0, 1'b1, 4);
        check("d2_reentry_idx", 32'(digit_index2), 32'd0);
        check("d2_reentry_dig", 32'(digits2),      32'h6);
        press(1'b0, 1'b0, 1'b1, 4);
        check("d2_p2_digits",   32'(digits2),      32'h3);
        check("d2_p2_old",      32'(digits_old2),  32'h6);
        check("d2_p2_donecnt",  32'(done2_cnt),    32'd2);
        check("d1_untouched",   32'(digits),       32'h125);

        // New pass on dut: 7, 3, then cancel
        press(1'b1, 1'b0, 1'b0, 4);
        check("np_idx0",    32'(digit_index), 32'd0);
        check("np_held",    32'(digits),      32'h125);
        value = 4'd7;
        press(1'b1, 1'b0, 1'b0, 4);
        value = 4'd3;
        press(1'b1, 1'b0, 1'b0, 4);
        check("np_digits",  32'(digits),      32'h137);
        check("np_old",     32'(digits_old),  32'h025);
        press(1'b0, 1'b1, 1'b0, 4);
        check("cx_digits",  32'(digits),      32'h125);
        check("cx_old",     32'(digits_old),  32'h025);
        check("cx_idx",     32'(digit_index), 32'd0);
        check("cx_donecnt", 32'(done_cnt),    32'd1);

        // Committing an out-of-range switch value stores the clamp
        value = 4'd12;
        press(1'b1, 1'b0, 1'b0, 4);
        check("cl_digits",  32'(digits),      32'h129);
        check("cl_idx",     32'(digit_index), 32'd1);

        // Enter and cancel together at index 1: cancel only
        value = 4'd8;
        press(1'b1, 1'b1, 1'b0, 4);
        check("both_digits", 32'(digits),      32'h125);
        check("both_old",    32'(digits_old),  32'h025);
        check("both_idx",    32'(digit_index), 32'd0);

        // Long hold gives exactly one commit
        value = 4'd4;
        press(1'b1, 1'b0, 1'b0, 50);
        check("hold_idx",    32'(digit_index), 32'd1);
        check("hold_digits", 32'(digits),      32'h124);
        check("hold_old",    32'(digits_old),  32'h025);

        // Glitch that never spans a rising edge is not seen
        enter = 1'b1;
        #2;
        enter = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch_idx",    32'(digit_index), 32'd1);
        check("glitch_digits", 32'(digits),      32'h124);

        // Second digit, then reset mid-pass with enter held through reset
        value = 4'd6;
        press(1'b1, 1'b0, 1'b0, 4);
        check("mid_digits", 32'(digits),      32'h164);
        check("mid_idx",    32'(digit_index), 32'd2);
        value = 4'd5;
        enter = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mr_digits",  32'(digits),       32'h000);
        check("mr_old",     32'(digits_old),   32'h000);
        check("mr_idx",     32'(digit_index),  32'd0);
        check("mr_bin",     32'(value_bin),    32'd0);
        check("mr_donecnt", 32'(done_cnt),     32'd1);
        check("mr_d2",      32'(digits2),      32'h0);
        enter = 1'b0;
        repeat (5) @(negedge clk);

        // Full pass after reset: 3, 0, 9
        value = 4'd3;
        press(1'b1, 1'b0, 1'b0, 4);
        value = 4'd0;
        press(1'b1, 1'b0, 1'b0, 4);
        value = 4'd9;
        press(1'b1, 1'b0, 1'b0, 4);
        check("p3_digits",  32'(digits),      32'h903);
        check("p3_old",     32'(digits_old),  32'h000);
        check("p3_idx",     32'(digit_index), 32'd3);
        check("p3_donecnt", 32'(done_cnt),    32'd2);
        check("p3_bin",     32'(value_bin),   BIN_EN ? 32'd903 : 32'd0);

        // Cancel in DONE is ignored
        press(1'b0, 1'b1, 1'b0, 4);
        check("dc_idx",     32'(digit_index), 32'd3);
        check("dc_digits",  32'(digits),      32'h903);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
